// File: rtl/cpu_pkg.sv
// ============================================================================
// Module : cpu_pkg
// Brief  : Shared constants and types for the single-cycle 16-bit core.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    localparam int PC_W_DEF = 16;

    localparam logic [2:0] CCC_NE  = 3'b000;
    localparam logic [2:0] CCC_EQ  = 3'b001;
    localparam logic [2:0] CCC_GT  = 3'b010;
    localparam logic [2:0] CCC_LT  = 3'b011;
    localparam logic [2:0] CCC_GE  = 3'b100;
    localparam logic [2:0] CCC_LE  = 3'b101;
    localparam logic [2:0] CCC_OV  = 3'b110;
    localparam logic [2:0] CCC_UNC = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    typedef logic [2:0] flags_t;

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module : branch_cond
// Brief  : Combinational branch condition evaluator, (ccc, {Z,V,N}) -> cond.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
    import cpu_pkg::*;
(
    input  logic [2:0] ccc,
    input  flags_t     flags,
    output logic       cond
);

    logic w_z;
    logic w_v;
    logic w_n;

    assign w_z = flags[FLAG_Z];
    assign w_v = flags[FLAG_V];
    assign w_n = flags[FLAG_N];

    always_comb begin
        cond = 1'b0;
        case (ccc)
            CCC_NE:  cond = ~w_z;
            CCC_EQ:  cond = w_z;
            CCC_GT:  cond = ~w_z & ~w_n;
            CCC_LT:  cond = w_n;
            CCC_GE:  cond = w_z | ~w_n;
            CCC_LE:  cond = w_n | w_z;
            CCC_OV:  cond = w_v;
            CCC_UNC: cond = 1'b1;
            default: cond = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_flow_unit.sv
// ============================================================================
// Module : pc_flow_unit
// Brief  : Program counter, Z/V/N flag register, branch resolution and HALT.
//          Optional build macro PC_STALL_EN adds a stall input.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_flow_unit
    import cpu_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
)
(
    input  logic            clk,
    input  logic            rst,
`ifdef PC_STALL_EN
    input  logic            stall,
`endif
    input  logic            branch,
    input  logic            branch_reg,
    input  logic            halt,
    input  logic [2:0]      ccc,
    input  logic [8:0]      imm9,
    input  logic [PC_W-1:0] rs_data,
    input  logic [2:0]      alu_flags,
    input  logic [2:0]      flag_wr,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus2,
    output logic [2:0]      flags,
    output logic            taken,
    output logic            halted
);

    logic [PC_W-1:0] r_pc;
    flags_t          r_flags;
    logic            r_halted;
    logic            w_cond;
    logic            w_stall;
    logic [PC_W-1:0] w_pc_plus2;
    logic [PC_W-1:0] w_offset;
    logic [PC_W-1:0] w_pc_next;

`ifdef PC_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    // Condition always sees the registered flags, never this cycle's ALU result.
    branch_cond u_branch_cond (
        .ccc   (ccc),
        .flags (r_flags),
        .cond  (w_cond)
    );

    assign w_pc_plus2 = r_pc + PC_W'(2);
    assign w_offset   = {{(PC_W-10){imm9[8]}}, imm9, 1'b0};

    always_comb begin
        w_pc_next = w_pc_plus2;
        if (r_halted || halt) begin
            w_pc_next = r_pc;
        end else if (branch && w_cond) begin
            w_pc_next = w_pc_plus2 + w_offset;
        end else if (branch_reg && w_cond) begin
            w_pc_next = rs_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_flags  <= '0;
            r_halted <= 1'b0;
        end else if (!w_stall && !r_halted) begin
            r_pc     <= w_pc_next;
            r_halted <= halt;
            for (int i = 0; i < 3; i++) begin
                if (flag_wr[i]) begin
                    r_flags[i] <= alu_flags[i];
                end
            end
        end
    end

    assign pc       = r_pc;
    assign pc_plus2 = w_pc_plus2;
    assign flags    = r_flags;
    assign halted   = r_halted;
    assign taken    = ~r_halted & (branch | branch_reg) & w_cond;

endmodule

`default_nettype wire
